// File: rtl/fetch_pkg.sv
// Shared types and width helpers for the fetch-line generator.
// Widths derived here are used directly in the port lists of the importing modules.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_1000;
    localparam int          EPOCH_W_DEF  = 3;

    typedef logic [EPOCH_W_DEF-1:0] epoch_t;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    function automatic int clc_w(input int xlen, input int line_off);
        return xlen - line_off;
    endfunction

    function automatic int bank_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

endpackage

// File: rtl/fetch_clc_gen_redir_arb.sv
// Fixed-priority redirect arbiter: the lowest-index asserted source wins.
// Purely combinational so it can be exercised on its own.
module redir_arb #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 32
) (
    input  logic [NUM_SRC-1:0]      redir_valid,
    input  logic [NUM_SRC*XLEN-1:0] redir_target,
    output logic                    redir_any,
    output logic [XLEN-1:0]         redir_sel_target
);

    assign redir_any = |redir_valid;

    // Scan from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        redir_sel_target = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                redir_sel_target = redir_target[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/fetch_clc_gen.sv
// Fetch-line generator: issues groups of NUM_BANKS consecutive cache lines,
// steered to interleaved icache banks, with prioritised redirects, epochs and halt.
module fetch_clc_gen
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              LINE_OFF  = 4,
    parameter int              NUM_BANKS = 2,
    parameter int              NUM_SRC   = 4,
    parameter int              EPOCH_W   = EPOCH_W_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_SRC-1:0]                          redir_valid,
    input  logic [NUM_SRC*XLEN-1:0]                     redir_target,
    input  logic                                        halt,
    input  logic                                        out_ready,
    output logic                                        out_valid,
    output logic [clc_w(XLEN, LINE_OFF)-1:0]            out_clc,
    output logic [NUM_BANKS*clc_w(XLEN, LINE_OFF)-1:0]  out_bank_clc,
    output logic [bank_w(NUM_BANKS)-1:0]                out_start_bank,
    output logic [LINE_OFF-1:0]                         out_offset,
    output logic [EPOCH_W-1:0]                          out_epoch
);

    localparam int CLC_W  = clc_w(XLEN, LINE_OFF);
    localparam int BANK_W = bank_w(NUM_BANKS);

    fetch_state_e         state_reg, state_next;
    logic [CLC_W-1:0]     clc_reg, clc_next;
    logic [LINE_OFF-1:0]  offset_reg, offset_next;
    logic [EPOCH_W-1:0]   epoch_reg, epoch_next;
    logic                 redir_any;
    logic [XLEN-1:0]      redir_sel_target;
    logic [CLC_W-1:0]     group_base;

    redir_arb #(
        .NUM_SRC (NUM_SRC),
        .XLEN    (XLEN)
    ) u_redir_arb (
        .redir_valid      (redir_valid),
        .redir_target     (redir_target),
        .redir_any        (redir_any),
        .redir_sel_target (redir_sel_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= BOOT;
            clc_reg    <= RESET_PC[XLEN-1:LINE_OFF];
            offset_reg <= RESET_PC[LINE_OFF-1:0];
            epoch_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            clc_reg    <= clc_next;
            offset_reg <= offset_next;
            epoch_reg  <= epoch_next;
        end
    end

    // A redirect preempts everything, including a stalled group and a pending halt.
    always_comb begin
        state_next  = state_reg;
        clc_next    = clc_reg;
        offset_next = offset_reg;
        epoch_next  = epoch_reg;
        if (redir_any) begin
            state_next  = RUN;
            clc_next    = redir_sel_target[XLEN-1:LINE_OFF];
            offset_next = redir_sel_target[LINE_OFF-1:0];
            epoch_next  = epoch_reg + EPOCH_W'(1);
        end else begin
            case (state_reg)
                BOOT: state_next = RUN;
                RUN: begin
                    if (out_ready) begin
                        clc_next    = clc_reg + CLC_W'(NUM_BANKS);
                        offset_next = '0;
                        if (halt) begin
                            state_next = HALTED;
                        end
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    assign out_valid      = (state_reg == RUN);
    assign out_clc        = clc_reg;
    assign out_offset     = offset_reg;
    assign out_epoch      = epoch_reg;
    assign out_start_bank = clc_reg[BANK_W-1:0];
    assign group_base     = clc_reg & ~CLC_W'(NUM_BANKS - 1);

    // Banks below the start bank hold lines from the next aligned block.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            localparam logic [BANK_W-1:0] BANK_IDX = BANK_W'(gi);
            assign out_bank_clc[gi*CLC_W +: CLC_W] =
                group_base + CLC_W'(gi) +
                ((BANK_IDX < out_start_bank) ? CLC_W'(NUM_BANKS) : CLC_W'(0));
        end
    endgenerate

endmodule

// File: tb/tb_fetch_clc_gen.sv
// Directed bench for fetch_clc_gen with a per-cycle reference model,
// run on a 2-bank and a 4-bank instance driven by the same stimulus.
module tb_fetch_clc_gen;
    import fetch_pkg::*;

    localparam int XLEN = 32;
    localparam int LO   = 4;
    localparam int CW   = 28;
    localparam int NS   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NS-1:0]        redir_valid;
    logic [NS*XLEN-1:0]   redir_target;
    logic                 halt;
    logic                 out_ready;

    logic                 v2, v4;
    logic [CW-1:0]        clc2, clc4;
    logic [2*CW-1:0]      bank2;
    logic [4*CW-1:0]      bank4;
    logic [0:0]           sb2;
    logic [1:0]           sb4;
    logic [3:0]           off2, off4;
    logic [2:0]           ep2, ep4;

    int checks = 0;
    int errors = 0;

    logic          m_known = 1'b0;
    logic          m_boot [2];
    logic          m_halt [2];
    logic [CW-1:0] m_line [2];
    logic [3:0]    m_off  [2];
    epoch_t        m_ep   [2];

    always #5 clk = ~clk;

    fetch_clc_gen #(.NUM_BANKS(2)) dut (
        .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_target(redir_target),
        .halt(halt), .out_ready(out_ready), .out_valid(v2), .out_clc(clc2),
        .out_bank_clc(bank2), .out_start_bank(sb2), .out_offset(off2), .out_epoch(ep2)
    );

    fetch_clc_gen #(.NUM_BANKS(4)) dut4 (
        .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_target(redir_target),
        .halt(halt), .out_ready(out_ready), .out_valid(v4), .out_clc(clc4),
        .out_bank_clc(bank4), .out_start_bank(sb4), .out_offset(off4), .out_epoch(ep4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sel_target(input logic [NS-1:0] v, input logic [NS*XLEN-1:0] t);
        for (int i = 0; i < NS; i++) begin
            if (v[i]) return t[i*XLEN +: XLEN];
        end
        return 32'h0;
    endfunction

    // Reference model: advances one step per clock edge from the rules of the block.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_line[k] <= RESET_PC_DEF[31:4];
                m_off[k]  <= RESET_PC_DEF[3:0];
                m_ep[k]   <= '0;
                m_boot[k] <= 1'b1;
                m_halt[k] <= 1'b0;
            end else if (redir_valid != '0) begin
                m_line[k] <= CW'(sel_target(redir_valid, redir_target) >> LO);
                m_off[k]  <= 4'(sel_target(redir_valid, redir_target));
                m_ep[k]   <= m_ep[k] + 1'b1;
                m_boot[k] <= 1'b0;
                m_halt[k] <= 1'b0;
            end else if (m_boot[k]) begin
                m_boot[k] <= 1'b0;
            end else if (!m_halt[k] && out_ready) begin
                m_line[k] <= m_line[k] + CW'((k == 0) ? 2 : 4);
                m_off[k]  <= '0;
                if (halt) m_halt[k] <= 1'b1;
            end
        end
        if (rst) m_known <= 1'b1;
        if (!rst && v2 && out_ready)
            $display("accept nb2 clc=%h off=%h epoch=%0d", clc2, off2, ep2);
    end

    task automatic cmp(input int k, input logic v, input logic [CW-1:0] c, input logic [4*CW-1:0] bk,
                       input logic [1:0] sb, input logic [3:0] o, input logic [2:0] e);
        int n;
        logic [CW-1:0] l;
        n = (k == 0) ? 2 : 4;
        chk($sformatf("nb%0d valid", n), 64'(v), 64'(!m_boot[k] && !m_halt[k]));
        chk($sformatf("nb%0d clc", n), 64'(c), 64'(m_line[k]));
        chk($sformatf("nb%0d offset", n), 64'(o), 64'(m_off[k]));
        chk($sformatf("nb%0d epoch", n), 64'(e), 64'(m_ep[k]));
        chk($sformatf("nb%0d start_bank", n), 64'(sb), 64'(m_line[k] % n));
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < n; j++) begin
                l = m_line[k] + CW'(j);
                if (int'(l % n) == b)
                    chk($sformatf("nb%0d bank%0d", n, b), 64'(bk[b*CW +: CW]), 64'(l));
            end
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            cmp(0, v2, clc2, {56'b0, bank2}, {1'b0, sb2}, off2, ep2);
            cmp(1, v4, clc4, bank4, sb4, off4, ep4);
        end
    end

    task automatic redirect(input int src, input logic [31:0] tgt);
        redir_valid = '0;
        redir_valid[src] = 1'b1;
        redir_target[src*XLEN +: XLEN] = tgt;
    endtask

    initial begin
        rst = 1'b1; redir_valid = '0; redir_target = '0; halt = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset valid", 64'(v2), 64'd0);
        chk("reset clc", 64'(clc2), 64'h100);
        chk("reset epoch", 64'(ep2), 64'd0);
        rst = 1'b0;

        // free run
        @(negedge clk);
        chk("run clc", 64'(clc2), 64'h100);
        chk("run bank0", 64'(bank2[0 +: CW]), 64'h100);
        chk("run bank1", 64'(bank2[CW +: CW]), 64'h101);
        @(negedge clk);
        chk("run adv", 64'(clc2), 64'h102);
        chk("run adv nb4", 64'(clc4), 64'h104);

        // two sources, lower index wins
        redir_valid = 4'b0110;
        redir_target[1*XLEN +: XLEN] = 32'h2008;
        redir_target[2*XLEN +: XLEN] = 32'h3000;
        @(negedge clk);
        chk("redir clc", 64'(clc2), 64'h200);
        chk("redir offset", 64'(off2), 64'd8);
        chk("redir epoch", 64'(ep2), 64'd1);
        redir_valid = '0;
        @(negedge clk);
        chk("redir adv", 64'(clc2), 64'h202);
        chk("redir adv off", 64'(off2), 64'd0);

        // unaligned start on the 4-bank instance
        redirect(0, 32'h2010);
        @(negedge clk);
        chk("unal clc4", 64'(clc4), 64'h201);
        chk("unal sb4", 64'(sb4), 64'd1);
        chk("unal b0", 64'(bank4[0*CW +: CW]), 64'h204);
        chk("unal b1", 64'(bank4[1*CW +: CW]), 64'h201);
        chk("unal b3", 64'(bank4[3*CW +: CW]), 64'h203);
        redir_valid = '0;
        out_ready = 1'b0;

        // stall, redirect on the second stalled cycle
        @(negedge clk);
        chk("stall hold", 64'(clc2), 64'h201);
        redirect(3, 32'h5000);
        @(negedge clk);
        chk("stall redir clc", 64'(clc2), 64'h500);
        chk("stall redir epoch", 64'(ep2), 64'd3);
        redir_valid = '0;
        @(negedge clk);
        chk("stall no adv", 64'(clc2), 64'h500);

        // halt while stalled, then accept
        halt = 1'b1;
        repeat (2) @(negedge clk);
        chk("halt pend valid", 64'(v2), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("halted valid", 64'(v2), 64'd0);
        chk("halted clc", 64'(clc2), 64'h502);
        halt = 1'b0;
        @(negedge clk);
        chk("halt drop valid", 64'(v2), 64'd0);
        redirect(0, 32'h4000);
        @(negedge clk);
        chk("resume valid", 64'(v2), 64'd1);
        chk("resume clc", 64'(clc2), 64'h400);

        // redirect together with halt
        halt = 1'b1;
        redirect(2, 32'h6004);
        @(negedge clk);
        chk("redir+halt valid", 64'(v2), 64'd1);
        chk("redir+halt clc", 64'(clc2), 64'h600);
        halt = 1'b0;

        // address wrap
        redirect(1, 32'hFFFF_FFF4);
        @(negedge clk);
        chk("wrap clc", 64'(clc2), 64'hFFF_FFFF);
        chk("wrap bank1", 64'(bank2[CW +: CW]), 64'hFFF_FFFF);
        chk("wrap bank0", 64'(bank2[0 +: CW]), 64'h0);
        chk("wrap epoch", 64'(ep2), 64'd6);
        redir_valid = '0;
        @(negedge clk);
        chk("wrap adv", 64'(clc2), 64'h1);
        chk("wrap adv nb4", 64'(clc4), 64'h3);

        // back-to-back redirects wrap the epoch
        redirect(0, 32'h7000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("epoch step %0d", i), 64'(ep2), 64'((7 + i) & 7));
        end

        // reset overrides a simultaneous redirect
        rst = 1'b1;
        @(negedge clk);
        chk("rst+redir valid", 64'(v2), 64'd0);
        chk("rst+redir clc", 64'(clc2), 64'h100);
        chk("rst+redir epoch", 64'(ep2), 64'd0);
        rst = 1'b0;
        redir_valid = '0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_clc_gen.md
Name: fetch_clc_gen

Overview:
Parametrised fetch-line generator for the frontend. It produces a group of NUM_BANKS consecutive cache-line addresses per cycle, steered to interleaved icache banks. It arbitrates NUM_SRC prioritised redirect sources and hands groups to the icache with a valid/ready handshake. It tags every group with a redirect epoch and supports a halt mode. It sits between branch resolution/predictors and the icache tag stage.

Parameters:
XLEN, 32, address width
LINE_OFF, 4, log2 bytes per cache line; CLC_W = XLEN-LINE_OFF
NUM_BANKS, 2, icache banks = lines per fetch group; power of 2, >=2; BANK_W = log2(NUM_BANKS)
NUM_SRC, 4, redirect sources; index 0 = highest priority
EPOCH_W, 3, redirect epoch tag width
RESET_PC, 32'h0000_1000, fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
redir_valid  in  NUM_SRC  per-source redirect request
redir_target  in  NUM_SRC*XLEN  per-source target; source i occupies bits [i*XLEN +: XLEN]
halt  in  1  stop issuing after the current group (wfi/fence.i)
out_ready  in  1  icache accepts the group this cycle
out_valid  out  1  group valid
out_clc  out  CLC_W  first line of the group
out_bank_clc  out  NUM_BANKS*CLC_W  line address presented to each bank
out_start_bank  out  BANK_W  bank holding out_clc (out_clc mod NUM_BANKS)
out_offset  out  LINE_OFF  byte offset of the first valid instruction in out_clc
out_epoch  out  EPOCH_W  redirect epoch of this group

Behaviour:
- State: clc (CLC_W), offset, epoch, and FSM {BOOT, RUN, HALTED}. All outputs are driven from registers or from combinational decode of registers.
- Reset: clc=RESET_PC[XLEN-1:LINE_OFF]; offset=RESET_PC[LINE_OFF-1:0]; epoch=0; state=BOOT; out_valid=0.
- BOOT: exactly one cycle with out_valid=0, then RUN.
- RUN: out_valid=1.
  - On accept (out_valid & out_ready): clc += NUM_BANKS modulo 2^CLC_W (wrap 0xFFF_FFFF -> 0x000_0000 for defaults); offset <= 0.
  - While out_ready=0: clc, offset and epoch hold unchanged.
- Bank mapping: for each bank b, out_bank_clc[b] = the line L in [clc, clc+NUM_BANKS-1] with L mod NUM_BANKS == b, computed modulo 2^CLC_W. out_start_bank = clc[BANK_W-1:0].
- Redirect:
  - Any redir_valid bit selects the lowest-index asserted source.
  - Next cycle: clc = target[XLEN-1:LINE_OFF], offset = target[LINE_OFF-1:0], epoch += 1 (wraps modulo 2^EPOCH_W), state = RUN, out_valid = 1.
  - Redirect takes effect regardless of out_ready, halt or current state. It overrides a stalled group: that group is dropped without needing acceptance.
  - Latency is 1 cycle from redir_valid to the new out_clc.
- Halt:
  - halt in RUN with no redirect: if the current group is accepted that cycle, state becomes HALTED and clc advances normally. Otherwise stay in RUN, holding, until it is accepted.
  - HALTED: out_valid=0, clc holds. Only a redirect leaves HALTED (-> RUN). Deasserting halt alone does not resume.
- Simultaneous events:
  - redirect + accept: redirect wins; no +NUM_BANKS advance.
  - redirect + halt: redirect wins, state = RUN; halt is ignored that cycle.
  - Multiple sources: the lower index wins; other sources are discarded, not queued.
- Reset mid-operation overrides everything, including a redirect on the same cycle.
- out_valid never depends combinationally on out_ready.

Decomposition:
- Package fetch_pkg:
  - CLC_W/BANK_W derivation functions
  - fetch_state_e enum {BOOT, RUN, HALTED}
  - epoch_t typedef
  - RESET_PC default constant
- Sub-module redir_arb (parametrised on NUM_SRC, XLEN): fixed-priority select producing redir_any and redir_sel_target. It is combinational and separately unit-testable.
- Bank-address decode stays inline as a generate loop.

Test Plan:
- Reset then free run (defaults, out_ready=1) -> cycle 1 out_valid=0. Cycle 2: out_clc=0x100, bank0=0x100, bank1=0x101, offset=0, epoch=0. Cycle 3: out_clc=0x102.
- redir_valid=4'b0110, targets src1=0x2008, src2=0x3000 -> next cycle out_clc=0x200, out_offset=8, epoch=1, start_bank=0. After accept: out_clc=0x202, offset=0.
- Unaligned redirect to 0x2010, NUM_BANKS=4 -> out_clc=0x201, start_bank=1, bank addrs {0x204, 0x201, 0x202, 0x203}.
- out_ready=0 for 3 cycles, then a src3 redirect on the 2nd stalled cycle -> stalled group held for one cycle, then replaced by the redirect target with epoch incremented. No advance occurs.
- halt asserted with out_ready=0 for 2 cycles, then out_ready=1 -> group accepted, then out_valid=0. Dropping halt keeps out_valid=0. A src0 redirect to 0x4000 -> out_valid=1, out_clc=0x400.
- Wrap: redirect to 0xFFFF_FFF4 (NUM_BANKS=2) -> out_clc=0xFFF_FFFF, bank1=0xFFF_FFFF, bank0=0x000_0000. After accept, out_clc=0x000_0001. Eight redirects wrap epoch from 7 to 0.
